range_counter: RTL and testbench



---
 rtl/range_counter_if.sv | 21 ++
 rtl/range_counter.sv | 49 ++++
 tb/tb_range_counter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/range_counter_if.sv
// range_counter_if: count request, load and status bundle of one counter stage
interface range_counter_if #(
  parameter int Width = 4
);
  logic             enable;
  logic             up0_down1;
  logic             carry_in;
  logic             load;
  logic [Width-1:0] data;
  logic [Width-1:0] count;
  logic             carry_out;
  logic             overflow;
  modport master (
    output enable, up0_down1, carry_in, load, data,
    input  count, carry_out, overflow
  );
  modport slave (
    input  enable, up0_down1, carry_in, load, data,
    output count, carry_out, overflow
  );
endinterface

// File: rtl/range_counter.sv
// range_counter: up/down counter cycling Low..High with clamped load, cascade carry and overflow flag (COUNTER_STICKY_OVERFLOW_EN makes overflow sticky)
module range_counter #(
  parameter int High    = 9,
  parameter int Low     = 0,
  parameter int Initial = Low,
  parameter int Width   = 4
) (
  input logic             clk,
  input logic             rst,
  range_counter_if.slave  bus
);
  localparam logic [Width:0] HI = (Width+1)'(High);
  localparam logic [Width:0] LO = (Width+1)'(Low);
  localparam logic [Width-1:0] INIT = Width'(Initial);
  if (!(Low >= 0 && Low <= Initial && Initial <= High && High < 2**Width)) begin : g_bad_cfg
    $error("range_counter: illegal High/Low/Initial/Width combination");
  end
  logic [Width-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [Width:0]   cnt_x, data_x, clamped, stepped;
  logic             step, terminal, wrap;
  always_comb begin
    step     = bus.enable | bus.carry_in;
    cnt_x    = {1'b0, count_q};
    data_x   = {1'b0, bus.data};
    terminal = bus.up0_down1 ? (cnt_x == LO) : (cnt_x == HI);
    wrap     = step & ~bus.load & terminal;
    clamped  = data_x > HI ? HI : data_x < LO ? LO : data_x;
    stepped  = terminal ? (bus.up0_down1 ? HI : LO) : (bus.up0_down1 ? cnt_x - 1'b1 : cnt_x + 1'b1);
    count_d  = bus.load ? clamped[Width-1:0] : step ? stepped[Width-1:0] : count_q;
`ifdef COUNTER_STICKY_OVERFLOW_EN
    overflow_d = ~bus.load & (overflow_q | wrap);
`else
    overflow_d = wrap;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= INIT;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = wrap;
endmodule

// File: tb/tb_range_counter.sv
// tb_range_counter: model-checked directed test of range_counter plus a two-digit cascade
module tb_range_counter;
  localparam int HI = 9, LO = 1, INIT = 1, W = 4, N = HI - LO + 1;
`ifdef COUNTER_STICKY_OVERFLOW_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, casc_en = 1'b0;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  range_counter_if #(.Width(W)) bus ();
  range_counter_if #(.Width(W)) c0b ();
  range_counter_if #(.Width(W)) c1b ();
  range_counter #(.High(HI), .Low(LO), .Initial(INIT), .Width(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  range_counter #(.High(9), .Low(0), .Width(W)) st0 (.clk(clk), .rst(rst), .bus(c0b));
  range_counter #(.High(9), .Low(0), .Width(W)) st1 (.clk(clk), .rst(rst), .bus(c1b));
  assign c0b.enable = casc_en;
  assign c0b.carry_in = 1'b0;
  assign c0b.up0_down1 = 1'b0;
  assign c0b.load = 1'b0;
  assign c0b.data = '0;
  assign c1b.enable = 1'b0;
  assign c1b.carry_in = c0b.carry_out;
  assign c1b.up0_down1 = 1'b0;
  assign c1b.load = 1'b0;
  assign c1b.data = '0;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  int m_cnt = INIT, m_ovf = 0, steps = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = INIT;
      m_ovf = 0;
      steps = 0;
    end else begin
      if (casc_en) steps++;
      if (bus.load) begin
        m_cnt = bus.data > HI ? HI : bus.data < LO ? LO : int'(bus.data);
        m_ovf = 0;
      end else if (bus.enable || bus.carry_in) begin
        automatic bit w = bus.up0_down1 ? (m_cnt == LO) : (m_cnt == HI);
        m_cnt = LO + ((m_cnt - LO + (bus.up0_down1 ? N - 1 : 1)) % N);
        m_ovf = STICKY ? (m_ovf | int'(w)) : int'(w);
      end else if (!STICKY) m_ovf = 0;
    end
  end
  function automatic int exp_carry();
    if (bus.load || !(bus.enable || bus.carry_in)) return 0;
    return bus.up0_down1 ? int'(m_cnt == LO) : int'(m_cnt == HI);
  endfunction
  always @(negedge clk) begin
    chk("count", int'(bus.count), m_cnt);
    chk("overflow", int'(bus.overflow), m_ovf);
    chk("carry_out", int'(bus.carry_out), exp_carry());
    chk("c0_count", int'(c0b.count), steps % 10);
    chk("c1_count", int'(c1b.count), (steps / 10) % 10);
    chk("c0_carry", int'(c0b.carry_out), int'(casc_en && steps % 10 == 9));
    chk("c1_carry", int'(c1b.carry_out), int'(casc_en && steps % 100 == 99));
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  logic [7:0] vec [13] = '{8'b1000_0000, 8'b1000_0000, 8'b1100_0000, 8'b0010_0000, 8'b0110_0000,
                           8'b0000_0000, 8'b1001_0011, 8'b0001_1111, 8'b0010_0000, 8'b1110_0000,
                           8'b0000_0000, 8'b0101_0000, 8'b0110_0000};
  initial begin
    bus.enable = 0; bus.up0_down1 = 0; bus.carry_in = 0; bus.load = 0; bus.data = '0;
    #1 rst = 1;
    cyc(2);
    rst = 0;
    chk("lit_reset_count", int'(bus.count), 1);
    chk("lit_reset_ovf", int'(bus.overflow), 0);
    cyc(3);
    chk("lit_hold_count", int'(bus.count), 1);
    bus.enable = 1;
    cyc(3);
    chk("lit_pre_async", int'(bus.count), 4);
    #2 rst = 1;
    #1 chk("lit_async_count", int'(bus.count), 1);
    chk("lit_async_ovf", int'(bus.overflow), 0);
    bus.enable = 0;
    @(posedge clk);
    #1 rst = 0;
    bus.enable = 1;
    cyc(8);
    chk("lit_up_top", int'(bus.count), 9);
    chk("lit_up_carry", int'(bus.carry_out), 1);
    cyc(1);
    chk("lit_up_wrap", int'(bus.count), 1);
    chk("lit_up_ovf", int'(bus.overflow), 1);
    cyc(1);
    chk("lit_up_after", int'(bus.count), 2);
    chk("lit_ovf_after", int'(bus.overflow), int'(STICKY));
    cyc(18);
    bus.enable = 0; bus.load = 1; bus.data = 4'd2;
    cyc(1);
    bus.load = 0; bus.enable = 1; bus.up0_down1 = 1;
    #1 chk("lit_dn_nocarry", int'(bus.carry_out), 0);
    cyc(1);
    chk("lit_dn_low", int'(bus.count), 1);
    chk("lit_dn_carry", int'(bus.carry_out), 1);
    cyc(1);
    chk("lit_dn_wrap", int'(bus.count), 9);
    chk("lit_dn_ovf", int'(bus.overflow), 1);
    bus.up0_down1 = 0; bus.load = 1; bus.data = 4'd5;
    #1 chk("lit_load_nocarry", int'(bus.carry_out), 0);
    cyc(1);
    chk("lit_load5", int'(bus.count), 5);
    chk("lit_load_ovf", int'(bus.overflow), 0);
    bus.data = 4'd12;
    cyc(1);
    chk("lit_clamp_hi", int'(bus.count), 9);
    bus.data = 4'd0;
    cyc(1);
    chk("lit_clamp_lo", int'(bus.count), 1);
    bus.load = 0; bus.enable = 0;
    for (int i = 0; i < 13; i++) begin
      {bus.enable, bus.up0_down1, bus.carry_in, bus.load, bus.data} = vec[i];
      cyc(1);
    end
    bus.enable = 0; bus.carry_in = 0; bus.load = 0;
    rst = 1;
    cyc(1);
    rst = 0; casc_en = 1;
    cyc(100);
    casc_en = 0;
    chk("lit_casc_c0", int'(c0b.count), 0);
    chk("lit_casc_c1", int'(c1b.count), 0);
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
